// File: rtl/ann_accuracy_window.sv
`default_nettype none
//==============================================================================
// Module : ann_accuracy_window
// Sliding-window inference scoreboard with a multicycle percent-accuracy divider.
// Rev    : 1.0
//==============================================================================
module ann_accuracy_window #(
    parameter int NUM_CLASSES = 10,
    parameter int WINDOW      = 300,
    parameter int MATCH_MODE  = 0,
    parameter int ACC_W       = 9,
    parameter int CNT_W       = $clog2(WINDOW + 1)
) (
    input  logic                   clk,
    input  logic                   rst_overall_n,
    input  logic                   clear,
    input  logic                   sample_valid,
    input  logic [NUM_CLASSES-1:0] expected_output,
    input  logic [NUM_CLASSES-1:0] obtained_output,
    output logic [CNT_W-1:0]       correct_cnt,
    output logic [CNT_W-1:0]       total_cnt,
    output logic                   last_correct,
    output logic [ACC_W-1:0]       accuracy,
    output logic                   acc_valid,
    output logic                   busy
);

    localparam int C_PTR_W  = $clog2(WINDOW);
    localparam int C_DIV_W  = CNT_W + 7;
    localparam int C_ITER_W = $clog2(C_DIV_W);
    localparam int C_REM_W  = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_load;
    logic                  w_div;
    logic                  w_score;
    logic                  w_accept;
    logic                  w_old;
    logic [WINDOW-1:0]     r_hist;
    logic [C_PTR_W-1:0]    r_wptr;
    logic [CNT_W-1:0]      r_correct;
    logic [CNT_W-1:0]      r_total;
    logic                  r_last;
    logic                  r_dirty;
    logic [C_DIV_W-1:0]    r_num;
    logic [CNT_W-1:0]      r_den;
    logic [CNT_W-1:0]      r_rem;
    logic [C_ITER_W-1:0]   r_iter;
    logic [ACC_W-1:0]      r_acc;
    logic                  r_acc_valid;
    logic [C_REM_W-1:0]    w_trial;
    logic [C_REM_W-1:0]    w_sub;
    logic                  w_ge;
    logic [C_DIV_W-1:0]    w_q_next;
    logic                  w_last_iter;

    generate
        if (MATCH_MODE == 0) begin : g_exact
            assign w_score = (expected_output == obtained_output);
        end else begin : g_onehot
            logic w_onehot;
            assign w_onehot = (obtained_output != '0) &&
                              ((obtained_output & (obtained_output - NUM_CLASSES'(1))) == '0);
            assign w_score  = w_onehot && ((obtained_output & expected_output) != '0);
        end
    endgenerate

    assign w_accept = sample_valid && !clear;
    assign w_old    = r_hist[r_wptr];

    // Once the window is full the slot being overwritten holds the oldest score
    always_ff @(posedge clk or negedge rst_overall_n) begin
        if (!rst_overall_n) begin
            r_hist    <= '0;
            r_wptr    <= '0;
            r_correct <= '0;
            r_total   <= '0;
            r_last    <= 1'b0;
        end else if (clear) begin
            r_hist    <= '0;
            r_wptr    <= '0;
            r_correct <= '0;
            r_total   <= '0;
            r_last    <= 1'b0;
        end else if (w_accept) begin
            r_hist[r_wptr] <= w_score;
            r_wptr         <= (r_wptr == C_PTR_W'(WINDOW - 1)) ? '0 : r_wptr + C_PTR_W'(1);
            r_last         <= w_score;
            if (r_total < CNT_W'(WINDOW)) begin
                r_total <= r_total + CNT_W'(1);
                if (w_score) r_correct <= r_correct + CNT_W'(1);
            end else if (w_score && !w_old) begin
                r_correct <= r_correct + CNT_W'(1);
            end else if (!w_score && w_old) begin
                r_correct <= r_correct - CNT_W'(1);
            end
        end
    end

    // A sample landing in the LOAD cycle is not in the snapshot, so it must win
    always_ff @(posedge clk or negedge rst_overall_n) begin
        if (!rst_overall_n) begin
            r_dirty <= 1'b0;
        end else if (clear) begin
            r_dirty <= 1'b0;
        end else if (w_accept) begin
            r_dirty <= 1'b1;
        end else if (w_load) begin
            r_dirty <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_overall_n) begin
        if (!rst_overall_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_last_iter = (r_iter == C_ITER_W'(C_DIV_W - 1));

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_div  = 1'b0;
        busy   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_dirty) w_next = S_LOAD;
            end
            S_LOAD: begin
                busy   = 1'b1;
                w_load = 1'b1;
                w_next = (r_total == '0) ? S_DONE : S_DIV;
            end
            S_DIV: begin
                busy  = 1'b1;
                w_div = 1'b1;
                if (w_last_iter) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (clear) begin
            w_next = S_IDLE;
            w_load = 1'b0;
            w_div  = 1'b0;
        end
    end

    // Restoring step: dividend shifts out of r_num MSB while quotient bits shift in
    assign w_trial  = {r_rem, r_num[C_DIV_W-1]};
    assign w_sub    = w_trial - {1'b0, r_den};
    assign w_ge     = (w_trial >= {1'b0, r_den});
    assign w_q_next = {r_num[C_DIV_W-2:0], w_ge};

    always_ff @(posedge clk or negedge rst_overall_n) begin
        if (!rst_overall_n) begin
            r_num       <= '0;
            r_den       <= '0;
            r_rem       <= '0;
            r_iter      <= '0;
            r_acc       <= '0;
            r_acc_valid <= 1'b0;
        end else begin
            r_acc_valid <= clear || (w_next == S_DONE);
            if (clear) begin
                r_acc <= '0;
            end else if (w_load) begin
                r_num  <= C_DIV_W'(r_correct) * C_DIV_W'(100);
                r_den  <= r_total;
                r_rem  <= '0;
                r_iter <= '0;
                if (r_total == '0) r_acc <= '0;
            end else if (w_div) begin
                r_num  <= w_q_next;
                r_rem  <= CNT_W'(w_ge ? w_sub : w_trial);
                r_iter <= r_iter + C_ITER_W'(1);
                if (w_last_iter) r_acc <= ACC_W'(w_q_next[6:0]);
            end
        end
    end

    assign correct_cnt  = r_correct;
    assign total_cnt    = r_total;
    assign last_correct = r_last;
    assign accuracy     = r_acc;
    assign acc_valid    = r_acc_valid;

endmodule
`default_nettype wire

// File: tb/tb_ann_accuracy_window.sv
`default_nettype none
//==============================================================================
// Module : tb_ann_accuracy_window
// Randomized self-checking bench with a queue-based sliding-window reference.
// Rev    : 1.0
//==============================================================================
module tb_ann_accuracy_window;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       sample_valid;
    logic [9:0] exp_o;
    logic [9:0] obt_o;

    logic [8:0] a_correct, a_total, a_acc;
    logic       a_last, a_av, a_busy;
    logic [2:0] b_correct, b_total;
    logic [8:0] b_acc;
    logic       b_last, b_av, b_busy;
    logic [3:0] c_correct, c_total;
    logic [8:0] c_acc;
    logic       c_last, c_av, c_busy;

    int n_tests = 0;
    int n_fail  = 0;

    bit q_a[$];
    bit q_b[$];
    bit q_c[$];

    always #5 clk = ~clk;

    ann_accuracy_window u_dut (
        .clk(clk), .rst_overall_n(rst_n), .clear(clear), .sample_valid(sample_valid),
        .expected_output(exp_o), .obtained_output(obt_o),
        .correct_cnt(a_correct), .total_cnt(a_total), .last_correct(a_last),
        .accuracy(a_acc), .acc_valid(a_av), .busy(a_busy)
    );

    ann_accuracy_window #(.WINDOW(4)) u_dut_w4 (
        .clk(clk), .rst_overall_n(rst_n), .clear(clear), .sample_valid(sample_valid),
        .expected_output(exp_o), .obtained_output(obt_o),
        .correct_cnt(b_correct), .total_cnt(b_total), .last_correct(b_last),
        .accuracy(b_acc), .acc_valid(b_av), .busy(b_busy)
    );

    ann_accuracy_window #(.WINDOW(8), .MATCH_MODE(1)) u_dut_oh (
        .clk(clk), .rst_overall_n(rst_n), .clear(clear), .sample_valid(sample_valid),
        .expected_output(exp_o), .obtained_output(obt_o),
        .correct_cnt(c_correct), .total_cnt(c_total), .last_correct(c_last),
        .accuracy(c_acc), .acc_valid(c_av), .busy(c_busy)
    );

    function automatic int qsum(input bit q[$]);
        int s = 0;
        foreach (q[i]) s += int'(q[i]);
        return s;
    endfunction

    function automatic int exp_acc(input bit q[$]);
        if (q.size() == 0) return 0;
        return (100 * qsum(q)) / q.size();
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_models();
        q_a.delete();
        q_b.delete();
        q_c.delete();
    endtask

    task automatic send(input logic [9:0] e, input logic [9:0] o);
        sample_valid = 1'b1;
        exp_o        = e;
        obt_o        = o;
        step();
        sample_valid = 1'b0;
        q_a.push_back(e == o);
        if (q_a.size() > 300) void'(q_a.pop_front());
        q_b.push_back(e == o);
        if (q_b.size() > 4) void'(q_b.pop_front());
        q_c.push_back(($countones(o) == 1) && ((o & e) != 0));
        if (q_c.size() > 8) void'(q_c.pop_front());
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        clear_models();
    endtask

    task automatic settle(output int pulses);
        int  idle = 0;
        bit  done = 0;
        pulses = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (a_av) pulses++;
            if (!(a_busy || b_busy || c_busy)) idle++;
            else idle = 0;
            if (idle >= 3) begin
                done = 1;
                break;
            end
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL settle_timeout: busy=%0b required 0", a_busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; sample_valid = 1'b0; exp_o = '0; obt_o = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        n_tests++; if (a_correct !== 9'd0) begin n_fail++; $display("FAIL reset_correct: got %0d required 0", a_correct); end
        n_tests++; if (a_total !== 9'd0) begin n_fail++; $display("FAIL reset_total: got %0d required 0", a_total); end
        n_tests++; if (a_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %0b required 0", a_last); end
        n_tests++; if (a_acc !== 9'd0) begin n_fail++; $display("FAIL reset_acc: got %0d required 0", a_acc); end
        n_tests++; if (a_av !== 1'b0) begin n_fail++; $display("FAIL reset_acc_valid: got %0b required 0", a_av); end
        n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b required 0", a_busy); end
    endtask

    task automatic test_exact();
        int p;
        for (int i = 0; i < 4; i++) send(10'b0000000100, 10'b0000000100);
        n_tests++; if (a_correct !== 9'd4) begin n_fail++; $display("FAIL exact_correct: got %0d required 4", a_correct); end
        n_tests++; if (a_total !== 9'd4) begin n_fail++; $display("FAIL exact_total: got %0d required 4", a_total); end
        settle(p);
        n_tests++; if (p < 1) begin n_fail++; $display("FAIL exact_pulse: got %0d pulses required >=1", p); end
        n_tests++; if (a_acc !== 9'd100) begin n_fail++; $display("FAIL exact_acc: got %0d required 100", a_acc); end
    endtask

    task automatic test_latency();
        int p;
        int lat = -1;
        do_clear();
        settle(p);
        send(10'b0000000010, 10'b0000000001);
        n_tests++; if (a_last !== 1'b0) begin n_fail++; $display("FAIL latency_last: got %0b required 0", a_last); end
        for (int k = 2; k <= 40; k++) begin
            step();
            if (a_av === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_tests++; if (lat != 19) begin n_fail++; $display("FAIL latency_cycles: got %0d required 19", lat); end
        n_tests++; if (a_acc !== 9'd0) begin n_fail++; $display("FAIL latency_acc: got %0d required 0", a_acc); end
        settle(p);
    endtask

    task automatic test_partial();
        int p;
        do_clear();
        settle(p);
        for (int i = 0; i < 3; i++) send(10'b0000001000, 10'b0000001000);
        send(10'b0000001000, 10'b0000010000);
        settle(p);
        n_tests++; if (a_correct !== 9'd3) begin n_fail++; $display("FAIL partial_correct: got %0d required 3", a_correct); end
        n_tests++; if (a_total !== 9'd4) begin n_fail++; $display("FAIL partial_total: got %0d required 4", a_total); end
        n_tests++; if (a_acc !== 9'd75) begin n_fail++; $display("FAIL partial_acc75: got %0d required 75", a_acc); end
        send(10'b0000001000, 10'b0000001000);
        settle(p);
        n_tests++; if (a_acc !== 9'd80) begin n_fail++; $display("FAIL partial_acc80: got %0d required 80", a_acc); end
    endtask

    task automatic test_window4();
        int p;
        do_clear();
        settle(p);
        send(10'd4, 10'd4);
        send(10'd4, 10'd4);
        send(10'd2, 10'd1);
        send(10'd2, 10'd1);
        send(10'd2, 10'd1);
        n_tests++; if (b_total !== 3'd4) begin n_fail++; $display("FAIL w4_total: got %0d required 4", b_total); end
        n_tests++; if (b_correct !== 3'd1) begin n_fail++; $display("FAIL w4_correct: got %0d required 1", b_correct); end
        settle(p);
        n_tests++; if (b_acc !== 9'd25) begin n_fail++; $display("FAIL w4_acc: got %0d required 25", b_acc); end
        send(10'd4, 10'd4);
        n_tests++; if (b_correct !== 3'(qsum(q_b))) begin n_fail++; $display("FAIL w4_wrap_correct: got %0d required %0d", b_correct, qsum(q_b)); end
        settle(p);
    endtask

    task automatic test_onehot();
        int p;
        do_clear();
        send(10'b0000000110, 10'b0000000100);
        n_tests++; if (c_last !== 1'b1) begin n_fail++; $display("FAIL onehot_hit: got %0b required 1", c_last); end
        n_tests++; if (a_last !== 1'b0) begin n_fail++; $display("FAIL exact_mode_miss: got %0b required 0", a_last); end
        send(10'b0000000110, 10'b0000000101);
        n_tests++; if (c_last !== 1'b0) begin n_fail++; $display("FAIL onehot_multi: got %0b required 0", c_last); end
        send(10'b0000000110, 10'b0000000110);
        n_tests++; if (c_last !== 1'b0) begin n_fail++; $display("FAIL onehot_equal_multi: got %0b required 0", c_last); end
        n_tests++; if (a_last !== 1'b1) begin n_fail++; $display("FAIL exact_mode_hit: got %0b required 1", a_last); end
        settle(p);
        n_tests++; if (c_acc !== 9'(exp_acc(q_c))) begin n_fail++; $display("FAIL onehot_acc: got %0d required %0d", c_acc, exp_acc(q_c)); end
    endtask

    task automatic test_clear_mid();
        int p;
        int pulses = 0;
        do_clear();
        for (int i = 0; i < 5; i++) send(10'd8, 10'd8);
        settle(p);
        for (int i = 0; i < 6; i++) send(10'd8, (i % 2 == 0) ? 10'd8 : 10'd1);
        n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL burst_busy: got %0b required 1", a_busy); end
        n_tests++; if (a_correct !== 9'(qsum(q_a))) begin n_fail++; $display("FAIL burst_correct: got %0d required %0d", a_correct, qsum(q_a)); end
        step(); step(); step();
        do_clear();
        n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy: got %0b required 0", a_busy); end
        n_tests++; if (a_correct !== 9'd0) begin n_fail++; $display("FAIL clear_correct: got %0d required 0", a_correct); end
        n_tests++; if (a_total !== 9'd0) begin n_fail++; $display("FAIL clear_total: got %0d required 0", a_total); end
        n_tests++; if (a_acc !== 9'd0) begin n_fail++; $display("FAIL clear_acc: got %0d required 0", a_acc); end
        n_tests++; if (a_av !== 1'b1) begin n_fail++; $display("FAIL clear_pulse: got %0b required 1", a_av); end
        for (int i = 0; i < 40; i++) begin
            step();
            if (a_av) pulses++;
        end
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL clear_extra_pulses: got %0d required 0", pulses); end
    endtask

    task automatic test_reset_mid();
        int p;
        int pulses = 0;
        for (int i = 0; i < 3; i++) send(10'd16, 10'd16);
        settle(p);
        send(10'd16, 10'd16);
        step(); step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({a_correct, a_total, a_last, a_acc, a_av, a_busy} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got cnt=%0d tot=%0d last=%0b acc=%0d av=%0b busy=%0b required all 0",
                     a_correct, a_total, a_last, a_acc, a_av, a_busy);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_models();
        for (int i = 0; i < 40; i++) begin
            step();
            if (a_av) pulses++;
        end
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL rstmid_pulses: got %0d required 0", pulses); end
        n_tests++; if (a_acc !== 9'd0) begin n_fail++; $display("FAIL rstmid_acc: got %0d required 0", a_acc); end
    endtask

    task automatic test_random();
        int p;
        logic [9:0] e, o, oh;
        for (int n = 0; n < 500; n++) begin
            oh = 10'd1 << $urandom_range(0, 9);
            e  = ($urandom_range(0, 1) == 0) ? oh : 10'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    o = e;
                2:       o = 10'd1 << $urandom_range(0, 9);
                default: o = 10'($urandom);
            endcase
            if ($urandom_range(0, 149) == 0) do_clear();
            send(e, o);
            n_tests++; if (a_correct !== 9'(qsum(q_a)) || a_total !== 9'(q_a.size())) begin
                n_fail++; $display("FAIL rnd_main_counts: got %0d/%0d required %0d/%0d", a_correct, a_total, qsum(q_a), q_a.size());
            end
            n_tests++; if (b_correct !== 3'(qsum(q_b)) || b_total !== 3'(q_b.size())) begin
                n_fail++; $display("FAIL rnd_w4_counts: got %0d/%0d required %0d/%0d", b_correct, b_total, qsum(q_b), q_b.size());
            end
            n_tests++; if (c_correct !== 4'(qsum(q_c)) || c_last !== q_c[q_c.size()-1]) begin
                n_fail++; $display("FAIL rnd_oh_counts: got %0d last=%0b required %0d last=%0b", c_correct, c_last, qsum(q_c), q_c[q_c.size()-1]);
            end
            if ($urandom_range(0, 3) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 20)); g++) step();
            end
        end
        settle(p);
        n_tests++; if (a_acc !== 9'(exp_acc(q_a))) begin n_fail++; $display("FAIL rnd_main_acc: got %0d required %0d", a_acc, exp_acc(q_a)); end
        n_tests++; if (b_acc !== 9'(exp_acc(q_b))) begin n_fail++; $display("FAIL rnd_w4_acc: got %0d required %0d", b_acc, exp_acc(q_b)); end
        n_tests++; if (c_acc !== 9'(exp_acc(q_c))) begin n_fail++; $display("FAIL rnd_oh_acc: got %0d required %0d", c_acc, exp_acc(q_c)); end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_latency();
        test_partial();
        test_window4();
        test_onehot();
        test_clear_mid();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
